// File: rtl/mc_mem_bridge.sv
// mc_mem_bridge: turns one multi-cycle-controller memory step into a single-beat,
// handshaked, word-aligned bus transaction (fetch -> IR, load -> MDR, store with
// byte enables). Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mc_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_start,
   input  logic        mem_sel,
   input  logic        mem_wr_en,
   input  logic [1:0]  mem_size,
   input  logic        ld_unsigned,
   input  logic [31:0] pc,
   input  logic [31:0] alu_addr,
   input  logic [31:0] store_data,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic [31:0] ir,
   output logic [31:0] mdr,
   output logic        mem_busy,
   output logic        mem_done,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_bus_addr;
   logic        r_bus_we;
   logic [3:0]  r_bus_be;
   logic [31:0] r_bus_wdata;
   logic [1:0]  r_lane;
   logic [1:0]  r_size;
   logic        r_uns;
   logic        r_sel;
   logic        r_misalign;
   logic [31:0] r_ir;
   logic [31:0] r_mdr;

   logic [31:0] w_addr;
   logic [1:0]  w_size;
   logic        w_misalign;
   logic        w_store;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_load_data;
   logic        w_timeout;

   // Request decode: effective address/size, alignment check, store lanes
   always_comb begin
      w_addr     = mem_sel ? alu_addr : pc;
      w_size     = mem_sel ? mem_size : 2'b10;
      w_store    = mem_sel & mem_wr_en;
      w_misalign = (w_size == 2'b11) ||
                   ((w_size == 2'b01) && w_addr[0]) ||
                   ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
      w_be       = 4'b1111;
      w_wdata    = '0;
      if (w_store) begin
         case (w_size)
            2'b00:   begin
                        w_be    = 4'b0001 << w_addr[1:0];
                        w_wdata = {4{store_data[7:0]}};
                     end
            2'b01:   begin
                        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                        w_wdata = {2{store_data[15:0]}};
                     end
            default: w_wdata = store_data;
         endcase
      end
   end

   // Load data extraction: shift selected lane down, then sign/zero extend
   always_comb begin
      w_shifted = bus_rdata >> {r_lane, 3'b000};
      case (r_size)
         2'b00:   w_load_data = r_uns ? {24'h000000, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_load_data = r_uns ? {16'h0000, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_load_data = bus_rdata;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] r_tcnt;
   logic          r_bus_err;

   // Timeout counter: held at zero outside ACCESS, counts ACCESS cycles without ack
   always_ff @(posedge clk) begin
      if (!rst_n || r_state != S_ACCESS) r_tcnt <= '0;
      else if (!bus_ack)                 r_tcnt <= r_tcnt + 1'b1;
   end

   // Ack in the terminal cycle takes priority over the timeout
   assign w_timeout = (r_state == S_ACCESS) && !bus_ack &&
                      (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

   // Bus error flag: cleared on every new request, set on timeout
   always_ff @(posedge clk) begin
      if (!rst_n)                                   r_bus_err <= 1'b0;
      else if (r_state == S_IDLE && mem_start)      r_bus_err <= 1'b0;
      else if (w_timeout)                           r_bus_err <= 1'b1;
   end

   assign bus_err = mem_done & r_bus_err;
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
   assign w_timeout    = 1'b0;
   assign bus_err      = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (mem_start) w_next = w_misalign ? S_DONE : S_ACCESS;
         S_ACCESS: if (bus_ack || w_timeout) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Request latch on start, IR/MDR update on ack
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bus_addr  <= '0;
         r_bus_we    <= 1'b0;
         r_bus_be    <= '0;
         r_bus_wdata <= '0;
         r_lane      <= '0;
         r_size      <= '0;
         r_uns       <= 1'b0;
         r_sel       <= 1'b0;
         r_misalign  <= 1'b0;
         r_ir        <= 32'h0000_0013;
         r_mdr       <= '0;
      end else begin
         if (r_state == S_IDLE && mem_start) begin
            r_misalign <= w_misalign;
            if (!w_misalign) begin
               r_bus_addr  <= {w_addr[31:2], 2'b00};
               r_bus_we    <= w_store;
               r_bus_be    <= w_be;
               r_bus_wdata <= w_wdata;
               r_lane      <= w_addr[1:0];
               r_size      <= w_size;
               r_uns       <= ld_unsigned;
               r_sel       <= mem_sel;
            end
         end
         if (r_state == S_ACCESS && bus_ack) begin
            if (!r_sel)         r_ir  <= bus_rdata;
            else if (!r_bus_we) r_mdr <= w_load_data;
         end
      end
   end

   assign bus_req      = (r_state == S_ACCESS);
   assign mem_busy     = (r_state != S_IDLE);
   assign mem_done     = (r_state == S_DONE);
   assign misalign_err = mem_done & r_misalign;
   assign bus_addr     = r_bus_addr;
   assign bus_we       = r_bus_we;
   assign bus_be       = r_bus_be;
   assign bus_wdata    = r_bus_wdata;
   assign ir           = r_ir;
   assign mdr          = r_mdr;

endmodule

// File: tb/tb_mc_mem_bridge.sv
// Self-checking bench for mc_mem_bridge: vector table of single accesses plus
// hand-written sequences for reset mid-access and (with MEM_TIMEOUT_EN) timeout.
module tb_mc_mem_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_start, mem_sel, mem_wr_en, ld_unsigned;
   logic [1:0]  mem_size;
   logic [31:0] pc, alu_addr, store_data, bus_rdata;
   logic        bus_ack;
   logic        bus_req, bus_we, mem_busy, mem_done, misalign_err, bus_err;
   logic [31:0] bus_addr, bus_wdata, ir, mdr;
   logic [3:0]  bus_be;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   mc_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .mem_start(mem_start), .mem_sel(mem_sel),
      .mem_wr_en(mem_wr_en), .mem_size(mem_size), .ld_unsigned(ld_unsigned),
      .pc(pc), .alu_addr(alu_addr), .store_data(store_data),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .ir(ir), .mdr(mdr), .mem_busy(mem_busy), .mem_done(mem_done),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        sel;
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] rdata;
      int unsigned reqc;     // ACCESS cycle in which ack is given (1 = first)
      logic        extra;    // pulse a second mem_start while busy
      logic        mis;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic        e_we;
      logic [31:0] e_wdata;
      logic [31:0] e_ir;
      logic [31:0] e_mdr;
   } vec_t;

   vec_t vecs[16];

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      mem_sel     = v.sel;
      mem_wr_en   = v.wr;
      mem_size    = v.size;
      ld_unsigned = v.uns;
      pc          = v.sel ? 32'h0BAD_0000 : v.addr;
      alu_addr    = v.sel ? v.addr : 32'h0BAD_0004;
      store_data  = v.sd;
      bus_rdata   = v.rdata;
      bus_ack     = 1'b0;
      mem_start   = 1'b1;
      @(negedge clk);
      mem_start = 1'b0;
      if (v.mis) begin
         check({tag, " mis done"}, {31'd0, mem_done}, 32'd1);
         check({tag, " mis err"}, {31'd0, misalign_err}, 32'd1);
         check({tag, " mis req"}, {31'd0, bus_req}, 32'd0);
         check({tag, " mis ir"}, ir, v.e_ir);
         check({tag, " mis mdr"}, mdr, v.e_mdr);
      end else begin
         for (int unsigned c = 1; c <= v.reqc; c++) begin
            check({tag, " req"}, {31'd0, bus_req}, 32'd1);
            check({tag, " done early"}, {31'd0, mem_done}, 32'd0);
            check({tag, " addr"}, bus_addr, v.e_addr);
            check({tag, " be"}, {28'd0, bus_be}, {28'd0, v.e_be});
            check({tag, " we"}, {31'd0, bus_we}, {31'd0, v.e_we});
            if (v.e_we) check({tag, " wdata"}, bus_wdata, v.e_wdata);
            bus_ack = (c == v.reqc);
            if (v.extra && c == 2) begin
               mem_start = 1'b1;
               alu_addr  = 32'h0000_0999;
            end else begin
               mem_start = 1'b0;
            end
            @(negedge clk);
         end
         bus_ack   = 1'b0;
         mem_start = 1'b0;
         check({tag, " done"}, {31'd0, mem_done}, 32'd1);
         check({tag, " req off"}, {31'd0, bus_req}, 32'd0);
         check({tag, " mis flag"}, {31'd0, misalign_err}, 32'd0);
         check({tag, " bus_err"}, {31'd0, bus_err}, 32'd0);
         check({tag, " ir"}, ir, v.e_ir);
         check({tag, " mdr"}, mdr, v.e_mdr);
      end
      @(negedge clk);
      check({tag, " done pulse"}, {31'd0, mem_done}, 32'd0);
      check({tag, " idle"}, {31'd0, mem_busy}, 32'd0);
      check({tag, " req idle"}, {31'd0, bus_req}, 32'd0);
      // A stray ack in IDLE must not disturb IR/MDR
      bus_ack   = 1'b1;
      bus_rdata = 32'h5A5A_5A5A;
      @(negedge clk);
      bus_ack = 1'b0;
      check({tag, " no 2nd done"}, {31'd0, mem_done}, 32'd0);
      check({tag, " ir hold"}, ir, v.e_ir);
      check({tag, " mdr hold"}, mdr, v.e_mdr);
   endtask

   initial begin
      //          sel  wr   size   uns  addr          sd            rdata         reqc ext  mis  e_addr        e_be     we   e_wdata       e_ir          e_mdr
      vecs[0]  = '{1'b0,1'b0,2'b10,1'b0,32'h0000_0100,32'h0,        32'h0050_0093,1,  1'b0,1'b0,32'h0000_0100,4'b1111,1'b0,32'h0,        32'h0050_0093,32'h0000_0000};
      vecs[1]  = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0203,32'h0,        32'h80FF_1234,1,  1'b0,1'b0,32'h0000_0200,4'b1111,1'b0,32'h0,        32'h0050_0093,32'hFFFF_FF80};
      vecs[2]  = '{1'b1,1'b0,2'b00,1'b1,32'h0000_0203,32'h0,        32'h80FF_1234,1,  1'b0,1'b0,32'h0000_0200,4'b1111,1'b0,32'h0,        32'h0050_0093,32'h0000_0080};
      vecs[3]  = '{1'b1,1'b1,2'b01,1'b0,32'h0000_0042,32'hDEAD_BEEF,32'h1111_1111,1,  1'b0,1'b0,32'h0000_0040,4'b1100,1'b1,32'hBEEF_BEEF,32'h0050_0093,32'h0000_0080};
      vecs[4]  = '{1'b1,1'b0,2'b10,1'b0,32'h0000_0101,32'h0,        32'h2222_2222,1,  1'b0,1'b1,32'h0,        4'b0000,1'b0,32'h0,        32'h0050_0093,32'h0000_0080};
      vecs[5]  = '{1'b1,1'b0,2'b01,1'b0,32'h0000_0202,32'h0,        32'h80FF_1234,3,  1'b0,1'b0,32'h0000_0200,4'b1111,1'b0,32'h0,        32'h0050_0093,32'hFFFF_80FF};
      vecs[6]  = '{1'b1,1'b0,2'b01,1'b1,32'h0000_0200,32'h0,        32'h1234_ABCD,1,  1'b0,1'b0,32'h0000_0200,4'b1111,1'b0,32'h0,        32'h0050_0093,32'h0000_ABCD};
      vecs[7]  = '{1'b1,1'b1,2'b00,1'b0,32'h0000_0031,32'h0000_00A5,32'h0,        2,  1'b0,1'b0,32'h0000_0030,4'b0010,1'b1,32'hA5A5_A5A5,32'h0050_0093,32'h0000_ABCD};
      vecs[8]  = '{1'b1,1'b1,2'b10,1'b0,32'h0000_0044,32'h1234_5678,32'h0,        1,  1'b0,1'b0,32'h0000_0044,4'b1111,1'b1,32'h1234_5678,32'h0050_0093,32'h0000_ABCD};
      vecs[9]  = '{1'b1,1'b0,2'b10,1'b0,32'h0000_0008,32'h0,        32'hCAFE_F00D,1,  1'b0,1'b0,32'h0000_0008,4'b1111,1'b0,32'h0,        32'h0050_0093,32'hCAFE_F00D};
      vecs[10] = '{1'b1,1'b0,2'b00,1'b0,32'h0000_0001,32'h0,        32'h0000_7F00,1,  1'b0,1'b0,32'h0000_0000,4'b1111,1'b0,32'h0,        32'h0050_0093,32'h0000_007F};
      vecs[11] = '{1'b1,1'b0,2'b11,1'b0,32'h0000_0000,32'h0,        32'h3333_3333,1,  1'b0,1'b1,32'h0,        4'b0000,1'b0,32'h0,        32'h0050_0093,32'h0000_007F};
      vecs[12] = '{1'b0,1'b0,2'b00,1'b0,32'h0000_0102,32'h0,        32'h4444_4444,1,  1'b0,1'b1,32'h0,        4'b0000,1'b0,32'h0,        32'h0050_0093,32'h0000_007F};
      vecs[13] = '{1'b0,1'b1,2'b00,1'b0,32'h0000_0004,32'hFFFF_FFFF,32'h00A0_0113,1,  1'b0,1'b0,32'h0000_0004,4'b1111,1'b0,32'h0,        32'h00A0_0113,32'h0000_007F};
      vecs[14] = '{1'b1,1'b0,2'b01,1'b0,32'h0000_0003,32'h0,        32'h5555_5555,1,  1'b0,1'b1,32'h0,        4'b0000,1'b0,32'h0,        32'h00A0_0113,32'h0000_007F};
      vecs[15] = '{1'b1,1'b0,2'b10,1'b0,32'h0000_0020,32'h0,        32'h1122_3344,5,  1'b1,1'b0,32'h0000_0020,4'b1111,1'b0,32'h0,        32'h00A0_0113,32'h1122_3344};

      rst_n = 1'b0; mem_start = 1'b0; mem_sel = 1'b0; mem_wr_en = 1'b0;
      mem_size = 2'b10; ld_unsigned = 1'b0; pc = '0; alu_addr = '0;
      store_data = '0; bus_rdata = '0; bus_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rst bus_req", {31'd0, bus_req}, 32'd0);
      check("rst bus_we", {31'd0, bus_we}, 32'd0);
      check("rst busy", {31'd0, mem_busy}, 32'd0);
      check("rst done", {31'd0, mem_done}, 32'd0);
      check("rst mis", {31'd0, misalign_err}, 32'd0);
      check("rst bus_err", {31'd0, bus_err}, 32'd0);
      check("rst addr", bus_addr, 32'd0);
      check("rst be", {28'd0, bus_be}, 32'd0);
      check("rst wdata", bus_wdata, 32'd0);
      check("rst mdr", mdr, 32'd0);
      check("rst ir", ir, 32'h0000_0013);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

      // Reset during ACCESS: outputs return to reset values, no done, late ack ignored
      @(negedge clk);
      mem_sel = 1'b1; mem_wr_en = 1'b1; mem_size = 2'b10; alu_addr = 32'h0000_0080;
      store_data = 32'h0F0F_0F0F; mem_start = 1'b1;
      @(negedge clk);
      mem_start = 1'b0;
      check("rr req", {31'd0, bus_req}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rr req", {31'd0, bus_req}, 32'd0);
      check("rr we", {31'd0, bus_we}, 32'd0);
      check("rr busy", {31'd0, mem_busy}, 32'd0);
      check("rr done", {31'd0, mem_done}, 32'd0);
      check("rr addr", bus_addr, 32'd0);
      check("rr be", {28'd0, bus_be}, 32'd0);
      check("rr ir", ir, 32'h0000_0013);
      check("rr mdr", mdr, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
      @(negedge clk);
      bus_ack = 1'b0;
      check("rr late ack done", {31'd0, mem_done}, 32'd0);
      check("rr late ack mdr", mdr, 32'd0);
      @(negedge clk);
      check("rr late ack done2", {31'd0, mem_done}, 32'd0);

`ifdef MEM_TIMEOUT_EN
      // No ack: four ACCESS cycles, then done with bus_err
      mem_sel = 1'b1; mem_wr_en = 1'b0; mem_size = 2'b10; alu_addr = 32'h0000_0010;
      bus_rdata = 32'h9999_9999; mem_start = 1'b1;
      @(negedge clk);
      mem_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check("to req", {31'd0, bus_req}, 32'd1);
         check("to done early", {31'd0, mem_done}, 32'd0);
         @(negedge clk);
      end
      check("to done", {31'd0, mem_done}, 32'd1);
      check("to bus_err", {31'd0, bus_err}, 32'd1);
      check("to req off", {31'd0, bus_req}, 32'd0);
      check("to mdr", mdr, 32'd0);
      @(negedge clk);
      check("to idle", {31'd0, mem_busy}, 32'd0);
      // Ack in the terminal cycle wins
      mem_start = 1'b1;
      @(negedge clk);
      mem_start = 1'b0;
      repeat (3) @(negedge clk);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      check("to ack done", {31'd0, mem_done}, 32'd1);
      check("to ack bus_err", {31'd0, bus_err}, 32'd0);
      check("to ack mdr", mdr, 32'h9999_9999);
      @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_mem_bridge.md
# mc_mem_bridge

Memory bridge for the multi-cycle RISC-V core. It sits directly downstream of the multi-cycle controller and turns one controller memory step into a single-beat, handshaked, word-aligned bus transaction. It performs instruction fetch into the instruction register (IR), data loads into the memory data register (MDR) with sign/zero extension, and byte/half/word stores with byte enables. The controller holds its current state until `mem_done`.

## Interface
- Clocking and reset: one clock; reset is synchronous and active-low.

Parameters:
- `TIMEOUT_CYCLES`, default 16: number of cycles `bus_req` may stay high without `bus_ack` before the access is aborted. Used only when `MEM_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `mem_start`  in  1  one-cycle request from controller; sampled only in IDLE.
- `mem_sel`  in  1  0 = fetch (address `pc`, result to IR); 1 = data (address `alu_addr`).
- `mem_wr_en`  in  1  store when `mem_sel`=1; ignored when `mem_sel`=0.
- `mem_size`  in  2  00 byte, 01 half, 10 word, 11 illegal; fetch forces word.
- `ld_unsigned`  in  1  1 = zero-extend load (funct3[2]); 0 = sign-extend.
- `pc`, `alu_addr`, `store_data`  in  32 each.
- `bus_req`, `bus_we`  out  1 each.
- `bus_addr`  out  32  always word aligned ([1:0]=00).
- `bus_be`  out  4.
- `bus_wdata`  out  32.
- `bus_rdata`  in  32.
- `bus_ack`  in  1  single-cycle acknowledge.
- `ir`, `mdr`  out  32 each, registered.
- `mem_busy`  out  1  high in every state except IDLE.
- `mem_done`  out  1  one-cycle completion pulse.
- `misalign_err`, `bus_err`  out  1 each  valid only while `mem_done`=1.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, `mem_start`=1, access aligned:
  - Latch address, `bus_we`, `bus_be`, `bus_wdata`, lane offset, size and signedness.
  - Go to ACCESS.
- IDLE, `mem_start`=1, access misaligned:
  - Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or `mem_size`=11.
  - Go to DONE with `misalign_err`=1. No bus cycle is issued; IR and MDR are unchanged.
- ACCESS:
  - `bus_req`=1, and the bus outputs are held stable.
  - On `bus_ack`: a fetch loads IR with `bus_rdata`; a load loads MDR with extracted data; a store updates neither. Then go to DONE.
- DONE: `mem_done`=1 for exactly one cycle, then return to IDLE.
- Byte lanes are little-endian, with lane = addr[1:0].
- Stores:
  - Byte: `be`=0001<<lane, `wdata`={4{sd[7:0]}}.
  - Half: `be`=0011 when addr[1]=0, 1100 when addr[1]=1; `wdata`={2{sd[15:0]}}.
  - Word: `be`=1111.
- Loads and fetch: `bus_be`=1111. The selected byte or half is shifted right by 8×lane, then sign- or zero-extended to 32 bits.
- A `mem_start` received outside IDLE is ignored and not queued.
- `bus_ack` received outside ACCESS is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `bus_req`, `bus_we`, `mem_busy`, `mem_done`, `misalign_err`, `bus_err` = 0.
  - `bus_addr`, `bus_be`, `bus_wdata`, `mdr` = 0.
  - `ir` = 32'h00000013 (NOP).
- Start sampled at edge N: `bus_req` is high from cycle N+1.
- Ack sampled at edge M: IR/MDR are valid, `mem_done`=1 and `bus_req`=0 in cycle M+1, and the block is back in IDLE at M+2.
- Minimum start-to-done latency is 2 cycles (ack in the first ACCESS cycle).
- Misaligned access: `mem_done` and `misalign_err` both = 1 in cycle N+1, and `bus_req` never rises.
- A new `mem_start` may be issued in the cycle after `mem_done`.
- Reset asserted mid-access: at the next edge all outputs return to their reset values and no `mem_done` is produced. A late `bus_ack` is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entering ACCESS and increments in each ACCESS cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE with `bus_err`=1 and `bus_req` drops; IR and MDR are unchanged.
  - An ack arriving in the same cycle as the terminal count wins, and `bus_err` stays 0.
- `MEM_TIMEOUT_EN` not defined: ACCESS waits indefinitely, no counter is built, and `bus_err` is tied to 0.

## Test plan
- Fetch, ack on first ACCESS cycle:
  - Stimulus: `pc`=0x100, `bus_rdata`=0x00500093.
  - Required: `bus_addr`=0x100, `bus_be`=1111; `ir`=0x00500093 with `mem_done` exactly 2 cycles after start.
- Signed byte load:
  - Stimulus: `alu_addr`=0x203, `bus_rdata`=0x80FF1234, `ld_unsigned`=0.
  - Required: `bus_addr`=0x200; `mdr`=0xFFFFFF80.
  - Repeat with `ld_unsigned`=1: required `mdr`=0x00000080.
- Half store:
  - Stimulus: `alu_addr`=0x42, `store_data`=0xDEADBEEF, `mem_size`=01.
  - Required: `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xBEEFBEEF; `mdr` unchanged.
- Misaligned word load:
  - Stimulus: `alu_addr`=0x101.
  - Required: `misalign_err`=1 and `mem_done` 1 cycle after start; `bus_req` stays 0.
- Ack delayed 5 cycles, plus a second `mem_start` pulsed while busy:
  - Required: a single transaction; `bus_req` high for 5 cycles with stable outputs; exactly one `mem_done`.
- With `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, ack never given:
  - Required: `bus_err`=1 with `mem_done` after 4 ACCESS cycles.
  - Separately, assert `rst_n`=0 during ACCESS: required `bus_req`=0 on the next cycle and no `mem_done`.
